iddmm_res_collect: RTL

Result collector that sits directly downstream of the IDDMM controller. On a host `start`, it raises `task_req` toward the controller. It then captures the N-word K-bit result burst, qualified by `task_grant` and terminated by `task_end`, into a local N×K buffer. Finally it drains the buffer word-serially to the next stage over a valid/ready handshake, and flags malformed bursts.

---
 rtl/iddmm_res_collect_if.sv | 31 +++
 rtl/iddmm_res_collect.sv | 125 ++++++++++++
 2 files changed

// File: rtl/iddmm_res_collect_if.sv
// Handshake bundle between the host, the IDDMM controller and the downstream
// consumer of the result collector. The slave modport is the collector's view.
interface iddmm_res_collect_if #(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N)
);
  logic              start;
  logic              busy;
  logic              task_req;
  logic              task_grant;
  logic              task_end;
  logic [K-1:0]      task_res;
  logic              out_valid;
  logic              out_ready;
  logic [K-1:0]      out_data;
  logic [ADDR_W-1:0] out_idx;
  logic              out_last;
  logic              done;
  logic              err;

  modport master (
    output start, task_grant, task_end, task_res, out_ready,
    input  busy, task_req, out_valid, out_data, out_idx, out_last, done, err
  );

  modport slave (
    input  start, task_grant, task_end, task_res, out_ready,
    output busy, task_req, out_valid, out_data, out_idx, out_last, done, err
  );
endinterface

// File: rtl/iddmm_res_collect.sv
// Captures one N-word IDDMM result burst into a local buffer, then drains it
// word-serially over valid/ready, flagging bursts that are not exactly N words.
module iddmm_res_collect #(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N)
) (
  input logic                 clk,
  input logic                 rst_n,
  iddmm_res_collect_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

  // Pointers carry one extra bit so they can sit at N without wrapping.
  localparam logic [ADDR_W:0] N_P    = (ADDR_W+1)'(N);
  localparam logic [ADDR_W:0] LAST_P = (ADDR_W+1)'(N-1);
  localparam logic [ADDR_W:0] ONE_P  = (ADDR_W+1)'(1);

  state_t            state_q;
  logic [ADDR_W:0]   wr_ptr_q;
  logic [ADDR_W:0]   rd_ptr_q;
  logic              busy_q;
  logic              task_req_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              done_q;
  logic              err_q;
  logic [K-1:0]      out_data_q;
  logic [ADDR_W-1:0] out_idx_q;
  logic [K-1:0]      mem_q [N];

  logic              wr_room;
  logic              wr_en;
  logic              rd_load;
  logic              out_hs;
  logic [ADDR_W:0]   cap_cnt_d;

  assign wr_room   = (wr_ptr_q < N_P);
  assign wr_en     = (state_q == S_REQ) && bus.task_grant && wr_room;
  // Words captured so far including the one arriving this cycle.
  assign cap_cnt_d = wr_en ? (wr_ptr_q + ONE_P) : wr_ptr_q;
  assign out_hs    = out_valid_q && bus.out_ready;
  assign rd_load   = (state_q == S_DRAIN) && (rd_ptr_q < N_P) &&
                     (!out_valid_q || bus.out_ready);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[ADDR_W-1:0]] <= bus.task_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      busy_q      <= 1'b0;
      task_req_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q    <= S_REQ;
            busy_q     <= 1'b1;
            task_req_q <= 1'b1;
            wr_ptr_q   <= '0;
            err_q      <= 1'b0;
          end
        end
        S_REQ: begin
          if (wr_en) begin
            wr_ptr_q <= cap_cnt_d;
          end
          // Overflow words are dropped; the burst is already malformed.
          if (bus.task_grant && !wr_room) begin
            err_q <= 1'b1;
          end
          if (bus.task_end) begin
            state_q    <= S_DRAIN;
            task_req_q <= 1'b0;
            rd_ptr_q   <= '0;
            if (cap_cnt_d != N_P) begin
              err_q <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (rd_load) begin
            out_data_q  <= mem_q[rd_ptr_q[ADDR_W-1:0]];
            out_idx_q   <= rd_ptr_q[ADDR_W-1:0];
            out_last_q  <= (rd_ptr_q == LAST_P);
            out_valid_q <= 1'b1;
            rd_ptr_q    <= rd_ptr_q + ONE_P;
          end else if (out_hs) begin
            out_valid_q <= 1'b0;
          end
          if (out_hs && out_last_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.task_req  = task_req_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_last  = out_last_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
